// File: rtl/my_pkg.sv
// Shared ALU definitions: op encoding, response record and the op decode function.
package my_pkg;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             dbz;
        logic [TAG_W-1:0] tag;
    } alu_rsp_t;

    // Unsigned op decode; carry only from ADD, dbz only from DIV.
    function automatic alu_rsp_t alu_eval(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input alu_op_e          op,
                                          input logic [TAG_W-1:0] tag);
        alu_rsp_t       r;
        logic [WIDTH:0] sum;
        r     = '0;
        r.tag = tag;
        sum   = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD: begin
                r.result = sum[WIDTH-1:0];
                r.carry  = sum[WIDTH];
            end
            OP_SUB:  r.result = a - b;
            OP_MUL:  r.result = a * b;
            OP_DIV: begin
                if (b == '0) begin
                    r.result = '1;
                    r.dbz    = 1'b1;
                end else begin
                    r.result = a / b;
                end
            end
            OP_SHL:  r.result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  r.result = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  r.result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  r.result = {a[0], a[WIDTH-1:1]};
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            OP_NOR:  r.result = ~(a | b);
            OP_NAND: r.result = ~(a & b);
            OP_XNOR: r.result = ~(a ^ b);
            OP_GT:   r.result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   r.result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: r.result = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO of ALU responses; head data reads as zero while empty.
module alu_rsp_fifo
    import my_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  alu_rsp_t               push_data,
    input  logic                   pop,
    output alu_rsp_t               pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    alu_rsp_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_seq_responder.sv
// Registered ALU service block: one-deep command stage feeding an in-order result FIFO.
// WIDTH/TAG_W must match the my_pkg defaults because the response record is fixed there.
// Handshake: a channel transfers on a rising edge where valid && ready are both high;
// valid does not wait on ready, and ready here never depends combinationally on out_ready.
module alu_seq_responder
    import my_pkg::*;
#(
    parameter int WIDTH = my_pkg::WIDTH,
    parameter int TAG_W = my_pkg::TAG_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_dbz,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      cmd_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_sel;
    logic [TAG_W-1:0] s1_tag;

    alu_rsp_t         s1_rsp;
    alu_rsp_t         head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;

    // Credit check counts the stage-1 entry as already occupying a FIFO slot,
    // so its push on the next edge can never be refused.
    assign in_ready = !rst && !fifo_full
                      && ((32'(fifo_count) + 32'(s1_valid)) < DEPTH);
    assign accept   = in_valid && in_ready;

    assign s1_rsp = alu_eval(s1_a, s1_b, s1_sel, s1_tag);

    // Capture accepted commands into stage 1 and count acceptances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= OP_ADD;
            s1_tag    <= '0;
            cmd_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_sel    <= alu_op_e'(in_sel);
                s1_tag    <= in_tag;
                cmd_count <= cmd_count + 16'd1;
            end
        end
    end

    alu_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (s1_rsp),
        .pop       (out_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_result = head.result;
    assign out_carry  = head.carry;
    assign out_dbz    = head.dbz;
    assign out_tag    = head.tag;

endmodule

// File: doc/alu_seq_responder.md
# alu_seq_responder

- Registered, flow-controlled ALU service block. It accepts operation commands `{A, B, sel, tag}` over a valid/ready request channel and computes the same 16-op function set as the combinational `alu`.
- Results return in order over a valid/ready response channel. A small result FIFO absorbs consumer backpressure.
- It is the responding end of the ALU command interface: the hardware counterpart a stimulus initiator or a CPU-side sequencer talks to, replacing direct combinational drive of `alu`.

## Interface
- `WIDTH`, 8: operand and result width.
- `TAG_W`, 4: width of the opaque command tag returned with each result.
- `DEPTH`, 4: result FIFO entries (power of 2, ≥2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  block can accept a command this cycle.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_sel`  in  4  operation select (`alu_op_e`).
- `in_tag`  in  TAG_W  command tag.
- `out_valid`  out  1  result at FIFO head.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  WIDTH  ALU result.
- `out_carry`  out  1  carry-out (ADD only).
- `out_dbz`  out  1  divide-by-zero flag (DIV only).
- `out_tag`  out  TAG_W  tag of the originating command.
- `cmd_count`  out  16  number of accepted commands; wraps modulo 2^16.

## Operation
- Ops by `in_sel`, all unsigned:
  - 0 ADD `a+b`; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 1 SUB `a-b`, modulo 2^WIDTH.
  - 2 MUL, low WIDTH bits.
  - 3 DIV `a/b`; if b==0, result is all-ones and dbz=1.
  - 4 SHL `a<<1`; 5 SHR `a>>1`.
  - 6 ROL by 1; 7 ROR by 1.
  - 8 AND; 9 OR; A XOR.
  - B NOR; C NAND; D XNOR.
  - E GT: result = 1 if a>b, else 0.
  - F EQ: result = 1 if a==b, else 0.
  - carry=0 for every op except ADD; dbz=0 for every op except DIV.
- Accept on `in_valid && in_ready`. Operands, sel and tag are captured into the stage-1 register with `s1_valid=1`.
- Stage 1 computes combinationally. On the next edge `{result, carry, dbz, tag}` is pushed into the FIFO unconditionally.
- Credit rule: `in_ready = !rst && (fifo_count + s1_valid) < DEPTH`. A FIFO push is therefore never refused.
- Pop on `out_valid && out_ready`. Same-cycle push and pop is legal at any occupancy, including full and empty.
- `in_ready` accounts for the pop only on the following cycle. There is no combinational path from `out_ready` to `in_ready`.
- Responses are strictly in acceptance order. Each `out_tag` equals the `in_tag` of its command.
- `in_*` inputs are ignored when `in_valid=0` or `in_ready=0`.

## Timing
- Reset (async assert, sync release):
  - `in_ready=0`, `out_valid=0`.
  - `out_result`, `out_carry`, `out_dbz`, `out_tag` = 0.
  - `cmd_count=0`, `s1_valid=0`, FIFO empty.
- Latency: command accepted at edge k gives `out_valid=1` after edge k+1, provided the FIFO was empty.
- Throughput: 1 command/cycle while `out_ready=1`.
- Backpressure: with `out_ready=0`, exactly DEPTH commands are accepted, then `in_ready` drops. After the first pop, `in_ready` rises one cycle later.
- `out_*` data is stable while `out_valid=1 && out_ready=0`.
- Reset mid-operation discards stage-1 contents and all FIFO contents. No stale result appears after release.
- FIFO read and write pointers wrap modulo DEPTH. Full/empty is decided by a (log2 DEPTH + 1)-bit count.

## Structure
- Shared package `my_pkg` holds:
  - `alu_op_e`, a 4-bit enum for ops 0–F;
  - `alu_rsp_t`, a packed struct `{result, carry, dbz, tag}`;
  - the default `WIDTH`/`TAG_W` localparams.
- Op decode lives in a function in `my_pkg` so benches reuse it as the reference model.
- One sub-module: `alu_rsp_fifo`, a parameterised synchronous FIFO of `alu_rsp_t` with push, pop, count, full and empty.

## Test plan
- ADD a=0xFF b=0x01 → result 0x00, carry 1, dbz 0; `out_valid` one edge after acceptance.
- DIV a=0x40 b=0x00 → result 0xFF, dbz 1. DIV a=0x40 b=0x04 → result 0x10, dbz 0.
- Sweep sel 0..F with a=0xA5 b=0x3C, tags 0..F, back-to-back with `out_ready=1` → 1 result/cycle, tags in order, each result matches the `my_pkg` model (e.g. ROL → 0x4B, GT → 0x01).
- `out_ready=0`, drive 6 commands → exactly 4 accepted, `in_ready=0`. Raise `out_ready` → the 4 drain in order, then the remaining 2 are accepted.
- Assert `rst` with 3 results queued and 1 in stage 1 → all outputs 0 immediately. After release, a new ADD 0x01+0x02 returns 0x03 with only its own tag.
- Accept 65 537 commands → `cmd_count` reads 1 (wrap).
